// File: rtl/nios2_ocimem_pkg.sv
// rtl/nios2_ocimem_pkg.sv - shared types and jdo field positions for the OCI debug memory controller
package nios2_ocimem_pkg;

  localparam int OCIMEM_DEPTH_LOG2 = 8;
  localparam int OCIMEM_DATA_W     = 32;
  localparam int JDO_W             = 38;

  localparam int ADDR_HI = 33;
  localparam int ADDR_LO = 26;
  localparam int RD_EN   = 25;
  localparam int ERR_CLR = 24;
  localparam int DATA_HI = 34;
  localparam int DATA_LO = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_RD,
    ST_JTAG_RD
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } jop_t;

endpackage

// File: rtl/nios2_ocimem_if.sv
// rtl/nios2_ocimem_if.sv - JTAG command/monitor and CPU slave bundle of the OCI debug memory
interface nios2_ocimem_if
  import nios2_ocimem_pkg::*;
#(
  parameter int DEPTH_LOG2 = OCIMEM_DEPTH_LOG2,
  parameter int DATA_W     = OCIMEM_DATA_W
);
  logic [JDO_W-1:0]      jdo;
  logic                  take_action_ocimem_a;
  logic                  take_no_action_ocimem_a;
  logic                  take_action_ocimem_b;
  logic [DATA_W-1:0]     MonDReg;
  logic                  monitor_ready;
  logic                  monitor_error;
  logic [DEPTH_LOG2-1:0] cpu_address;
  logic                  cpu_read;
  logic                  cpu_write;
  logic [DATA_W-1:0]     cpu_writedata;
  logic [DATA_W-1:0]     cpu_readdata;
  logic                  cpu_waitrequest;

  modport slave (
    input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    input  cpu_address, cpu_read, cpu_write, cpu_writedata,
    output MonDReg, monitor_ready, monitor_error, cpu_readdata, cpu_waitrequest
  );

  modport master (
    output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    output cpu_address, cpu_read, cpu_write, cpu_writedata,
    input  MonDReg, monitor_ready, monitor_error, cpu_readdata, cpu_waitrequest
  );

endinterface

// File: rtl/nios2_ocimem_ram.sv
// rtl/nios2_ocimem_ram.sv - single-port synchronous debug RAM, one-cycle read latency
module nios2_ocimem_ram
  import nios2_ocimem_pkg::*;
#(
  parameter int DEPTH_LOG2 = OCIMEM_DEPTH_LOG2,
  parameter int DATA_W     = OCIMEM_DATA_W
)(
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic                  we,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/nios2_ocimem_ctrl.sv
// rtl/nios2_ocimem_ctrl.sv - JTAG/CPU arbiter and command decoder for the OCI debug RAM
module nios2_ocimem_ctrl
  import nios2_ocimem_pkg::*;
#(
  parameter int DEPTH_LOG2 = OCIMEM_DEPTH_LOG2,
  parameter int DATA_W     = OCIMEM_DATA_W
)(
  input  logic          clk,
  input  logic          reset,
  nios2_ocimem_if.slave bus
);

  state_t                state, state_nx;
  jop_t                  jop;
  logic                  jpend;
  logic [DEPTH_LOG2-1:0] mon_areg;
  logic [DATA_W-1:0]     mon_dreg;
  logic                  ready_q;
  logic                  error_q;

  logic [DEPTH_LOG2-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_q;
  logic                  jtag_issue;
  logic                  wait_rq;
  logic                  strobe;
  logic                  jdo_unused;

  assign strobe = bus.take_action_ocimem_a | bus.take_no_action_ocimem_a | bus.take_action_ocimem_b;
  assign jdo_unused = ^{bus.jdo[JDO_W-1:DATA_HI+1], bus.jdo[DATA_LO-1:0]};

  nios2_ocimem_ram #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // Port arbitration: CPU write, then CPU read, then the pending JTAG op.
  always_comb begin
    state_nx   = state;
    ram_addr   = mon_areg;
    ram_we     = 1'b0;
    ram_wdata  = mon_dreg;
    jtag_issue = 1'b0;
    wait_rq    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.cpu_write) begin
          ram_addr  = bus.cpu_address;
          ram_wdata = bus.cpu_writedata;
          ram_we    = 1'b1;
        end else if (bus.cpu_read) begin
          ram_addr = bus.cpu_address;
          wait_rq  = 1'b1;
          state_nx = ST_CPU_RD;
        end else if (jpend) begin
          jtag_issue = 1'b1;
          ram_we     = (jop == OP_WR);
          if (jop == OP_RD) begin
            state_nx = ST_JTAG_RD;
          end
        end
      end
      ST_CPU_RD: begin
        wait_rq  = bus.cpu_write;
        state_nx = ST_IDLE;
      end
      ST_JTAG_RD: begin
        wait_rq  = bus.cpu_read | bus.cpu_write;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // Nothing may reach the RAM while reset is held, even mid-cycle.
    if (reset) begin
      ram_we  = 1'b0;
      wait_rq = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      jop      <= OP_RD;
      jpend    <= 1'b0;
      mon_areg <= '0;
      mon_dreg <= '0;
      ready_q  <= 1'b1;
      error_q  <= 1'b0;
    end else begin
      state <= state_nx;

      if (state == ST_JTAG_RD) begin
        mon_dreg <= ram_q;
        ready_q  <= 1'b1;
        jpend    <= 1'b0;
      end
      if (jtag_issue && jop == OP_WR) begin
        mon_areg <= mon_areg + 1'b1;
        ready_q  <= 1'b1;
        jpend    <= 1'b0;
      end

      // A strobe while busy is dropped, but an address load still lands.
      if (strobe && jpend) begin
        error_q <= 1'b1;
        if (bus.take_action_ocimem_a) begin
          mon_areg <= bus.jdo[ADDR_HI:ADDR_LO];
        end
      end else if (bus.take_action_ocimem_a) begin
        mon_areg <= bus.jdo[ADDR_HI:ADDR_LO];
        if (bus.jdo[RD_EN]) begin
          jpend   <= 1'b1;
          jop     <= OP_RD;
          ready_q <= 1'b0;
        end
        if (bus.jdo[ERR_CLR]) begin
          error_q <= 1'b0;
        end
      end else if (bus.take_no_action_ocimem_a) begin
        mon_areg <= mon_areg + 1'b1;
        jpend    <= 1'b1;
        jop      <= OP_RD;
        ready_q  <= 1'b0;
      end else if (bus.take_action_ocimem_b) begin
        mon_dreg <= bus.jdo[DATA_HI:DATA_LO];
        jpend    <= 1'b1;
        jop      <= OP_WR;
        ready_q  <= 1'b0;
      end
    end
  end

  assign bus.MonDReg         = mon_dreg;
  assign bus.monitor_ready   = ready_q;
  assign bus.monitor_error   = error_q;
  assign bus.cpu_readdata    = (state == ST_CPU_RD) ? ram_q : '0;
  assign bus.cpu_waitrequest = wait_rq;

endmodule

// File: tb/tb_nios2_ocimem_ctrl.sv
// tb/tb_nios2_ocimem_ctrl.sv - directed self-checking bench for nios2_ocimem_ctrl
module tb_nios2_ocimem_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;

  nios2_ocimem_if bus ();

  nios2_ocimem_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[33:26] = a;
    j[25] = rd;
    j[24] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // kind: 0 = take_action_a, 1 = take_no_action_a, 2 = take_action_b
  task automatic strobe(input int kind, input logic [37:0] j);
    bus.jdo = j;
    bus.take_action_ocimem_a    = (kind == 0);
    bus.take_no_action_ocimem_a = (kind == 1);
    bus.take_action_ocimem_b    = (kind == 2);
    cycle();
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (bus.monitor_ready !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
    bus.cpu_address = a;
    bus.cpu_writedata = d;
    bus.cpu_write = 1'b1;
    cycle();
    bus.cpu_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d, output logic w0, output logic w1);
    bus.cpu_address = a;
    bus.cpu_read = 1'b1;
    #1 w0 = bus.cpu_waitrequest;
    cycle();
    w1 = bus.cpu_waitrequest;
    d = bus.cpu_readdata;
    cycle();
    bus.cpu_read = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        w0, w1;
    int          n;

    bus.jdo = '0;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_writedata = '0;

    repeat (3) cycle();
    chk("rst_mondreg", bus.MonDReg, 32'h0);
    chk("rst_ready", {31'b0, bus.monitor_ready}, 32'h1);
    chk("rst_error", {31'b0, bus.monitor_error}, 32'h0);
    chk("rst_readdata", bus.cpu_readdata, 32'h0);
    chk("rst_waitreq", {31'b0, bus.cpu_waitrequest}, 32'h0);
    reset = 1'b0;
    cycle();

    // Preload and JTAG address-load read
    bus.cpu_address = 8'h10;
    bus.cpu_writedata = 32'hDEADBEEF;
    bus.cpu_write = 1'b1;
    #1 chk("cpu_wr_waitreq", {31'b0, bus.cpu_waitrequest}, 32'h0);
    cycle();
    bus.cpu_write = 1'b0;
    strobe(0, jdo_a(8'h10, 1'b1, 1'b0));
    chk("rd_ready_cleared", {31'b0, bus.monitor_ready}, 32'h0);
    wait_ready(10, n);
    chk("rd_latency", n, 2);
    chk("rd_mondreg", bus.MonDReg, 32'hDEADBEEF);

    cpu_rd(8'h10, d, w0, w1);
    chk("cpu_rd_wait0", {31'b0, w0}, 32'h1);
    chk("cpu_rd_wait1", {31'b0, w1}, 32'h0);
    chk("cpu_rd_data", d, 32'hDEADBEEF);

    // Write burst wrapping 0xFF -> 0x00
    strobe(0, jdo_a(8'hFF, 1'b0, 1'b0));
    chk("load_only_ready", {31'b0, bus.monitor_ready}, 32'h1);
    strobe(2, jdo_b(32'h11111111));
    chk("wr_mondreg", bus.MonDReg, 32'h11111111);
    wait_ready(10, n);
    chk("wr_latency", n, 1);
    cycle();
    cycle();
    strobe(2, jdo_b(32'h22222222));
    wait_ready(10, n);
    chk("wr2_latency", n, 1);
    cpu_rd(8'hFF, d, w0, w1);
    chk("ram_ff", d, 32'h11111111);
    cpu_rd(8'h00, d, w0, w1);
    chk("ram_00", d, 32'h22222222);
    strobe(2, jdo_b(32'h33333333));
    wait_ready(10, n);
    cpu_rd(8'h01, d, w0, w1);
    chk("areg_after_wrap", d, 32'h33333333);

    // Read-next wraps too
    strobe(0, jdo_a(8'hFF, 1'b1, 1'b0));
    wait_ready(10, n);
    chk("rd_ff", bus.MonDReg, 32'h11111111);
    strobe(1, '0);
    wait_ready(10, n);
    chk("rdnext_latency", n, 2);
    chk("rdnext_wrap", bus.MonDReg, 32'h22222222);

    // Arbitration: four back-to-back CPU reads hold off a JTAG read
    cpu_wr(8'h20, 32'hCAFEF00D);
    bus.cpu_address = 8'h20;
    bus.cpu_read = 1'b1;
    bus.jdo = jdo_a(8'h10, 1'b1, 1'b0);
    bus.take_action_ocimem_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("arb_wait0_%0d", i), {31'b0, bus.cpu_waitrequest}, 32'h1);
      cycle();
      bus.take_action_ocimem_a = 1'b0;
      chk($sformatf("arb_data_%0d", i), bus.cpu_readdata, 32'hCAFEF00D);
      chk($sformatf("arb_jtag_held_%0d", i), {31'b0, bus.monitor_ready}, 32'h0);
      cycle();
    end
    bus.cpu_read = 1'b0;
    wait_ready(10, n);
    chk("arb_jtag_latency", n, 2);
    chk("arb_jtag_data", bus.MonDReg, 32'hDEADBEEF);

    // Dropped command and error clear
    strobe(0, jdo_a(8'h10, 1'b1, 1'b0));
    cycle();
    strobe(2, jdo_b(32'h99999999));
    chk("drop_error", {31'b0, bus.monitor_error}, 32'h1);
    chk("drop_ready", {31'b0, bus.monitor_ready}, 32'h1);
    chk("drop_mondreg", bus.MonDReg, 32'hDEADBEEF);
    cpu_rd(8'h10, d, w0, w1);
    chk("drop_ram", d, 32'hDEADBEEF);
    strobe(0, jdo_a(8'h00, 1'b0, 1'b1));
    chk("err_clear", {31'b0, bus.monitor_error}, 32'h0);

    // Same-cycle CPU and JTAG write to 0x40
    strobe(0, jdo_a(8'h40, 1'b0, 1'b0));
    bus.cpu_address = 8'h40;
    bus.cpu_writedata = 32'hAAAA0000;
    bus.cpu_write = 1'b1;
    strobe(2, jdo_b(32'h5555FFFF));
    bus.cpu_write = 1'b0;
    wait_ready(10, n);
    cpu_rd(8'h40, d, w0, w1);
    chk("collision", d, 32'h5555FFFF);

    // Reset asserted in the JTAG_RD cycle
    cpu_wr(8'h50, 32'h12345678);
    strobe(0, jdo_a(8'h50, 1'b1, 1'b0));
    strobe(2, jdo_b(32'hFFFFFFFF));
    chk("pre_rst_error", {31'b0, bus.monitor_error}, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_mondreg", bus.MonDReg, 32'h0);
    chk("mid_rst_ready", {31'b0, bus.monitor_ready}, 32'h1);
    chk("mid_rst_error", {31'b0, bus.monitor_error}, 32'h0);
    chk("mid_rst_readdata", bus.cpu_readdata, 32'h0);
    cycle();
    reset = 1'b0;
    cycle();
    cpu_rd(8'h50, d, w0, w1);
    chk("post_rst_ram", d, 32'h12345678);
    strobe(2, jdo_b(32'h0BADF00D));
    wait_ready(10, n);
    cpu_rd(8'h00, d, w0, w1);
    chk("post_rst_areg", d, 32'h0BADF00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
